mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_controller.sv | 134 +++++++++++++
 tb/tb_mem_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Word-addressed 32-bit memory behind a Valid/ready handshake with WAIT_CYCLES busy cycles per access.
// Define MEMCON_BOUNDS_CHECK_EN to flag and suppress accesses whose address is >= DEPTH.
module mem_controller #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Valid,
    input  logic        RW,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data,
    output logic        ready,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rw_q, rw_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             oor_q, oor_d;
    logic [31:0]      data_q, data_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             memWe;
    logic             inRange;

    logic [31:0] mem [DEPTH];

`ifdef MEMCON_BOUNDS_CHECK_EN
    assign inRange = (address < 32'(DEPTH));
`else
    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH.
    logic unusedAddrBits;
    assign unusedAddrBits = ^address[31:IDX_W];
    assign inRange        = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            data_q  <= 32'd0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // RELEASE waits for Valid to drop so a held request is served only once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Valid) state_d = BUSY;
            BUSY:    if (count_q == 4'd0) state_d = RELEASE;
            RELEASE: if (!Valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        data_d  = data_q;
        ready_d = ready_q;
        err_d   = 1'b0;
        memWe   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Valid) begin
                    idx_d   = address[IDX_W-1:0];
                    rw_d    = RW;
                    wdata_d = data_in;
                    oor_d   = !inRange;
                    count_d = 4'(WAIT_CYCLES);
                    ready_d = 1'b0;
                end
            end
            BUSY: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    err_d   = oor_q;
                    if (rw_q) begin
                        data_d = oor_q ? 32'd0 : mem[idx_q];
                    end else begin
                        memWe = !oor_q;
                    end
                end
            end
            RELEASE: ready_d = 1'b1;
            default: ready_d = 1'b1;
        endcase
    end

    // The array has no reset; writes only fire from BUSY, so a reset abort never commits one.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign data  = data_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: DUT 0 uses WAIT_CYCLES=2/DEPTH=1024, DUT 1 uses WAIT_CYCLES=0/DEPTH=16.
// Expectations follow MEMCON_BOUNDS_CHECK_EN so the same bench serves both builds.
module tb_mem_controller;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

`ifdef MEMCON_BOUNDS_CHECK_EN
    localparam logic [31:0] OOR_READ_DATA = 32'h0000_0000;
    localparam logic        OOR_ERR       = 1'b1;
    localparam logic [31:0] A5_FINAL      = 32'hDEAD_BEEF;
    localparam logic [31:0] B3_FINAL      = 32'h1234_5678;
`else
    localparam logic [31:0] OOR_READ_DATA = 32'hCAFE_F00D;
    localparam logic        OOR_ERR       = 1'b0;
    localparam logic [31:0] A5_FINAL      = 32'h55AA_55AA;
    localparam logic [31:0] B3_FINAL      = 32'h0F0F_0F0F;
`endif

    logic        clk;
    logic        reset;
    logic        validS [2];
    logic        rwS    [2];
    logic [31:0] addrS  [2];
    logic [31:0] dinS   [2];
    logic [31:0] dataS  [2];
    logic        readyS [2];
    logic        errS   [2];

    exp_t expQA[$];
    exp_t expQB[$];
    int   total = 0;
    int   bad   = 0;

    mem_controller #(.DEPTH(1024), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .reset(reset), .Valid(validS[0]), .RW(rwS[0]),
        .address(addrS[0]), .data_in(dinS[0]),
        .data(dataS[0]), .ready(readyS[0]), .err(errS[0])
    );

    mem_controller #(.DEPTH(16), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .reset(reset), .Valid(validS[1]), .RW(rwS[1]),
        .address(addrS[1]), .data_in(dinS[1]),
        .data(dataS[1]), .ready(readyS[1]), .err(errS[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endfunction

    function automatic void pushExp(int d, logic [31:0] data, logic err);
        exp_t e;
        e.data = data;
        e.err  = err;
        if (d == 0) expQA.push_back(e);
        else        expQB.push_back(e);
    endfunction

    function automatic void popAndCompare(int d);
        exp_t e;
        int   pending;
        pending = (d == 0) ? expQA.size() : expQB.size();
        checkOutput($sformatf("pendingExpectation[%0d]", d), {31'd0, pending > 0}, 32'd1);
        if (pending > 0) begin
            e = (d == 0) ? expQA.pop_front() : expQB.pop_front();
            checkOutput($sformatf("completionData[%0d]", d), dataS[d], e.data);
            checkOutput($sformatf("completionErr[%0d]", d), {31'd0, errS[d]}, {31'd0, e.err});
        end
    endfunction

    // Monitor: every rising edge of ready outside reset is one completed access.
    initial begin : monitor
        logic prevReady [2];
        prevReady[0] = 1'b1;
        prevReady[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    prevReady[d] = 1'b1;
                end else begin
                    if (!prevReady[d] && readyS[d]) popAndCompare(d);
                    prevReady[d] = readyS[d];
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input logic rw, input logic [31:0] addr,
                                 input logic [31:0] din, input logic [31:0] expData,
                                 input logic expErr, input int hold, input int expLow);
        int lowCount;
        bit done;
        @(negedge clk);
        validS[d] = 1'b1;
        rwS[d]    = rw;
        addrS[d]  = addr;
        dinS[d]   = din;
        pushExp(d, expData, expErr);
        lowCount = 0;
        done     = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                rwS[d]   = ~rw;
                addrS[d] = ~addr;
                dinS[d]  = ~din;
            end
            if (readyS[d]) done = 1'b1;
            else           lowCount++;
        end
        checkOutput($sformatf("completedInTime[%0d]", d), {31'd0, done}, 32'd1);
        checkOutput($sformatf("readyLowCycles[%0d]", d), lowCount, expLow);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("readyHeld[%0d]", d), {31'd0, readyS[d]}, 32'd1);
            checkOutput($sformatf("dataHeld[%0d]", d), dataS[d], expData);
        end
        @(negedge clk);
        validS[d] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput($sformatf("errOneCycle[%0d]", d), {31'd0, errS[d]}, 32'd0);
        checkOutput($sformatf("dataAfterRelease[%0d]", d), dataS[d], expData);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            validS[d] = 1'b0;
            rwS[d]    = 1'b0;
            addrS[d]  = 32'd0;
            dinS[d]   = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("resetReady[%0d]", d), {31'd0, readyS[d]}, 32'd1);
            checkOutput($sformatf("resetData[%0d]", d), dataS[d], 32'd0);
            checkOutput($sformatf("resetErr[%0d]", d), {31'd0, errS[d]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // DUT 0: two-wait-cycle controller
        applyStimulus(0, 1'b0, 32'd0,     32'hCAFE_F00D, 32'h0000_0000, 1'b0, 0, 3);
        applyStimulus(0, 1'b0, 32'd5,     32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 3);
        applyStimulus(0, 1'b1, 32'd5,     32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0, 3);
        applyStimulus(0, 1'b0, 32'd9,     32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0, 0, 3);
        applyStimulus(0, 1'b1, 32'd9,     32'h0000_0000, 32'h0BAD_F00D, 1'b0, 10, 3);
        applyStimulus(0, 1'b1, 32'd5,     32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0, 3);
        applyStimulus(0, 1'b0, 32'd7,     32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 0, 3);

        // Abort a write to address 7 while the controller is busy
        @(negedge clk);
        validS[0] = 1'b1;
        rwS[0]    = 1'b0;
        addrS[0]  = 32'd7;
        dinS[0]   = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        checkOutput("abortBusyReady", {31'd0, readyS[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abortReady", {31'd0, readyS[0]}, 32'd1);
        checkOutput("abortData", dataS[0], 32'd0);
        checkOutput("abortErr", {31'd0, errS[0]}, 32'd0);
        validS[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(0, 1'b1, 32'd7,     32'h0000_0000, 32'h0000_0001, 1'b0, 0, 3);
        applyStimulus(0, 1'b1, 32'h400,   32'h0000_0000, OOR_READ_DATA, OOR_ERR, 0, 3);
        applyStimulus(0, 1'b0, 32'h405,   32'h55AA_55AA, OOR_READ_DATA, OOR_ERR, 0, 3);
        applyStimulus(0, 1'b1, 32'd5,     32'h0000_0000, A5_FINAL, 1'b0, 0, 3);

        // DUT 1: zero-wait-cycle controller, back-to-back requests
        applyStimulus(1, 1'b0, 32'd3,     32'h1234_5678, 32'h0000_0000, 1'b0, 0, 1);
        applyStimulus(1, 1'b1, 32'd3,     32'h0000_0000, 32'h1234_5678, 1'b0, 0, 1);
        applyStimulus(1, 1'b0, 32'h13,    32'h0F0F_0F0F, 32'h1234_5678, OOR_ERR, 0, 1);
        applyStimulus(1, 1'b1, 32'd3,     32'h0000_0000, B3_FINAL, 1'b0, 0, 1);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboardDrainedA", expQA.size(), 32'd0);
        checkOutput("scoreboardDrainedB", expQB.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
